// File: rtl/framebuffer_stream_reader.sv
// -----------------------------------------------------------------------------
// framebuffer_stream_reader
//
// Purpose:
//   Fetch stage in front of the VGA scan-out block. Reads a linear 16-bpp frame
//   from memory as 32-bit words over a request/response read port. Streams it
//   out as AXI-Stream RGB565 pixels, one pixel per beat, low half of each word
//   first. Each rising edge of i_fsync restarts the frame from i_Frame_Base. If
//   the edge arrives mid-frame, the in-flight reads are drained and discarded.
//
// Ports:
//   i_Clock, i_Reset         clock; asynchronous active-high reset
//   i_Frame_Base             frame byte base address, captured on the fsync edge
//   i_fsync                  frame sync level from scan-out
//   o_Rd_Addr/o_Rd_Valid     read request (address held while not accepted)
//   i_Rd_Ready               request accepted on o_Rd_Valid && i_Rd_Ready
//   i_Rd_Data/_Valid         in-order read responses, no backpressure
//   m_axis_tdata/tvalid/     pixel stream; tlast marks the last pixel of a line
//   tready/tlast
//   o_Busy                   high whenever the FSM is not idle
//   o_Starve_Count           (STARVE_STATS_EN only) saturating count of cycles
//                            the sink was ready but no pixel was available
//
// Build option:
//   STARVE_STATS_EN          adds the starvation counter and o_Starve_Count.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for an fsync edge
// S_FETCH | issuing reads and streaming pixels until the frame is sent
// S_DRAIN | mid-frame abort: discard responses until none are outstanding
// -----------------------------------------------------------------------------
module framebuffer_stream_reader #(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [ADDR_WIDTH-1:0] i_Frame_Base,
    input  logic                  i_fsync,
    output logic [ADDR_WIDTH-1:0] o_Rd_Addr,
    output logic                  o_Rd_Valid,
    input  logic                  i_Rd_Ready,
    input  logic [31:0]           i_Rd_Data,
    input  logic                  i_Rd_Data_Valid,
    output logic [15:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  o_Busy
`ifdef STARVE_STATS_EN
    ,
    output logic [15:0]           o_Starve_Count
`endif
);

    localparam int WORDS = (H_PIXELS * V_LINES) / 2;
    localparam int WW    = $clog2(WORDS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int SW    = CW + 1;
    localparam int PW    = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int LW    = $clog2(V_LINES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    fsync_prev_q, fsync_prev_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [WW-1:0]           word_idx_q, word_idx_d;
    logic [CW-1:0]           outstanding_q, outstanding_d;
    logic [CW-1:0]           fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    half_q, half_d;
    logic [PW-1:0]           pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]           line_cnt_q, line_cnt_d;
    logic [31:0]             fifo_mem_q [FIFO_DEPTH];
    logic [31:0]             fifo_mem_d [FIFO_DEPTH];

    logic                    fsync_edge;
    logic [SW-1:0]           credit_sum;
    logic                    has_credit;
    logic                    rd_valid;
    logic                    rd_fire;
    logic                    rsp_accept;
    logic                    tvalid;
    logic                    tlast;
    logic                    pix_hs;
    logic                    last_pix_hs;
    logic                    pixels_left;
    logic [31:0]             fifo_head;
    logic                    start_frame;
    logic                    flush;
    logic                    push;
    logic                    pop;

    assign fsync_edge  = i_fsync & ~fsync_prev_q;

    // Words already in the FIFO plus words still in flight must fit in the
    // FIFO, so a response can never arrive without a free slot.
    assign credit_sum  = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
    assign has_credit  = credit_sum < SW'(FIFO_DEPTH);

    assign rd_valid    = (state_q == S_FETCH) && (word_idx_q != WW'(WORDS)) && has_credit;
    assign rd_fire     = rd_valid & i_Rd_Ready;

    // Responses beyond the outstanding count belong to requests issued before
    // a reset and are ignored.
    assign rsp_accept  = i_Rd_Data_Valid && (outstanding_q != '0);

    assign fifo_head   = fifo_mem_q[rd_ptr_q];
    assign tvalid      = (fifo_count_q != '0) && (state_q != S_DRAIN);
    assign tlast       = tvalid && (pix_cnt_q == PW'(H_PIXELS - 1));
    assign pix_hs      = tvalid & m_axis_tready;
    assign last_pix_hs = pix_hs && tlast && (line_cnt_q == LW'(V_LINES - 1));
    assign pixels_left = (line_cnt_q != LW'(V_LINES));

    assign o_Rd_Addr     = base_q + (ADDR_WIDTH'(word_idx_q) << 2);
    assign o_Rd_Valid    = rd_valid;
    assign m_axis_tdata  = half_q ? fifo_head[31:16] : fifo_head[15:0];
    assign m_axis_tvalid = tvalid;
    assign m_axis_tlast  = tlast;
    assign o_Busy        = (state_q != S_IDLE);

    always_comb begin
        state_d       = state_q;
        fsync_prev_d  = i_fsync;
        base_d        = base_q;
        word_idx_d    = word_idx_q;
        outstanding_d = outstanding_q;
        fifo_count_d  = fifo_count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        half_d        = half_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        fifo_mem_d    = fifo_mem_q;
        start_frame   = 1'b0;
        flush         = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;

        if (rd_fire && !rsp_accept) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!rd_fire && rsp_accept) begin
            outstanding_d = outstanding_q - 1'b1;
        end
        if (rd_fire) begin
            word_idx_d = word_idx_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (fsync_edge) begin
                    start_frame = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                // An edge together with the final pixel is a clean frame
                // boundary, so the next frame starts without draining.
                if (fsync_edge) begin
                    start_frame = 1'b1;
                    state_d     = last_pix_hs ? S_FETCH : S_DRAIN;
                end else if (last_pix_hs) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                flush = 1'b1;
                if (fsync_edge) begin
                    base_d = i_Frame_Base;
                end
                if (outstanding_q == '0) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        push = rsp_accept && (state_q == S_FETCH) && !start_frame;
        pop  = pix_hs && half_q;

        if (start_frame || flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
            half_d       = 1'b0;
        end else begin
            if (push) begin
                fifo_mem_d[wr_ptr_q] = i_Rd_Data;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (pix_hs) begin
                half_d = ~half_q;
            end
            if (push && !pop) begin
                fifo_count_d = fifo_count_q + 1'b1;
            end else if (!push && pop) begin
                fifo_count_d = fifo_count_q - 1'b1;
            end
        end

        if (start_frame) begin
            base_d     = i_Frame_Base;
            word_idx_d = '0;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
        end else if (pix_hs) begin
            if (tlast) begin
                pix_cnt_d  = '0;
                line_cnt_d = line_cnt_q + 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q       <= S_IDLE;
            fsync_prev_q  <= 1'b0;
            base_q        <= '0;
            word_idx_q    <= '0;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            half_q        <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fsync_prev_q  <= fsync_prev_d;
            base_q        <= base_d;
            word_idx_q    <= word_idx_d;
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            half_q        <= half_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            fifo_mem_q    <= fifo_mem_d;
        end
    end

`ifdef STARVE_STATS_EN
    logic [15:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if ((state_q == S_FETCH) && m_axis_tready && !tvalid && pixels_left
            && (starve_q != 16'hFFFF)) begin
            starve_d = starve_q + 16'd1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign o_Starve_Count = starve_q;
`else
    logic unused_pixels_left;
    assign unused_pixels_left = pixels_left;
`endif

    // The credit check makes a response into a full FIFO impossible.
    assert property (@(posedge i_Clock) disable iff (i_Reset)
        !(rsp_accept && (state_q == S_FETCH) && (fifo_count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_framebuffer_stream_reader.sv
module tb_framebuffer_stream_reader;

    logic        i_Clock = 1'b0;
    logic        i_Reset;
    logic [31:0] i_Frame_Base;
    logic        i_fsync;
    logic [31:0] o_Rd_Addr;
    logic        o_Rd_Valid;
    logic        i_Rd_Ready;
    logic [31:0] i_Rd_Data;
    logic        i_Rd_Data_Valid;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        o_Busy;
`ifdef STARVE_STATS_EN
    logic [15:0] o_Starve_Count;
`endif

    framebuffer_stream_reader #(
        .H_PIXELS  (4),
        .V_LINES   (2),
        .ADDR_WIDTH(32),
        .FIFO_DEPTH(4)
    ) dut (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .i_Frame_Base   (i_Frame_Base),
        .i_fsync        (i_fsync),
        .o_Rd_Addr      (o_Rd_Addr),
        .o_Rd_Valid     (o_Rd_Valid),
        .i_Rd_Ready     (i_Rd_Ready),
        .i_Rd_Data      (i_Rd_Data),
        .i_Rd_Data_Valid(i_Rd_Data_Valid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .o_Busy         (o_Busy)
`ifdef STARVE_STATS_EN
        ,
        .o_Starve_Count (o_Starve_Count)
`endif
    );

    always #5 i_Clock = ~i_Clock;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Memory model: response latency, ready control, response gate.
    int          lat         = 1;
    int          mem_allow   = 1000000;
    bit          rd_ready_en = 1'b1;
    int          cyc         = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_log[$];
    logic [15:0] pix_log[$];
    bit          last_log[$];

    logic        s_acc, s_pix, s_last;
    logic [31:0] s_addr, a;
    logic [15:0] s_data;

    // Word at byte address A holds pixels A and A+2 (low 16 bits of address).
    initial begin
        i_Rd_Ready      = 1'b0;
        i_Rd_Data_Valid = 1'b0;
        i_Rd_Data       = '0;
        forever begin
            @(negedge i_Clock);
            s_acc  = !i_Reset && o_Rd_Valid && i_Rd_Ready;
            s_addr = o_Rd_Addr;
            s_pix  = !i_Reset && m_axis_tvalid && m_axis_tready;
            s_data = m_axis_tdata;
            s_last = m_axis_tlast;
            @(posedge i_Clock);
            #1;
            cyc++;
            if (i_Reset) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (s_acc) begin
                    pend_addr.push_back(s_addr);
                    pend_due.push_back(cyc + lat - 1);
                    acc_log.push_back(s_addr);
                end
                if (s_pix) begin
                    pix_log.push_back(s_data);
                    last_log.push_back(s_last);
                end
            end
            i_Rd_Data_Valid = 1'b0;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc && mem_allow > 0) begin
                a               = pend_addr.pop_front();
                void'(pend_due.pop_front());
                i_Rd_Data       = {a[15:0] + 16'd2, a[15:0]};
                i_Rd_Data_Valid = 1'b1;
                mem_allow--;
            end
            i_Rd_Ready = rd_ready_en;
        end
    end

    task automatic tick();
        @(posedge i_Clock);
        #2;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        pix_log.delete();
        last_log.delete();
    endtask

    task automatic pulse_fsync(input logic [31:0] base);
        i_Frame_Base = base;
        i_fsync      = 1'b1;
        tick();
        i_fsync      = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_Busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        repeat (3) tick();
        i_Reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        i_fsync       = 1'b0;
        i_Frame_Base  = '0;
        m_axis_tready = 1'b0;
        i_Reset       = 1'b1;
        repeat (3) tick();
        total_cnt++; if (o_Rd_Valid !== 1'b0) $display("FAIL rst_rd_valid: got %b want 0", o_Rd_Valid); else pass_cnt++;
        total_cnt++; if (o_Rd_Addr !== 32'h0) $display("FAIL rst_rd_addr: got %h want 0", o_Rd_Addr); else pass_cnt++;
        total_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); else pass_cnt++;
        total_cnt++; if (m_axis_tdata !== 16'h0) $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); else pass_cnt++;
        total_cnt++; if (m_axis_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); else pass_cnt++;
        total_cnt++; if (o_Busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_Busy); else pass_cnt++;
        i_Reset = 1'b0;
        repeat (3) tick();
        total_cnt++; if ({o_Busy, o_Rd_Valid} !== 2'b00) $display("FAIL idle_no_fsync: got %b want 00", {o_Busy, o_Rd_Valid}); else pass_cnt++;
    endtask

    task automatic test_frame();
        logic [15:0] got;
        logic [31:0] ga;
        clear_logs();
        m_axis_tready = 1'b1;
        pulse_fsync(32'h1000);
        total_cnt++; if (o_Busy !== 1'b1) $display("FAIL t1_busy_rise: got %b want 1", o_Busy); else pass_cnt++;
        wait_idle();
        total_cnt++; if (o_Busy !== 1'b0) $display("FAIL t1_busy_fall: got %b want 0", o_Busy); else pass_cnt++;
        total_cnt++; if (acc_log.size() !== 4) $display("FAIL t1_read_count: got %0d want 4", acc_log.size()); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            ga = (i < acc_log.size()) ? acc_log[i] : 32'hFFFF_FFFF;
            total_cnt++;
            if (ga !== 32'h1000 + 32'(4 * i)) $display("FAIL t1_read_addr[%0d]: got %h want %h", i, ga, 32'h1000 + 32'(4 * i)); else pass_cnt++;
        end
        total_cnt++; if (pix_log.size() !== 8) $display("FAIL t1_pixel_count: got %0d want 8", pix_log.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            got = (i < pix_log.size()) ? pix_log[i] : 16'hFFFF;
            total_cnt++;
            if (got !== 16'h1000 + 16'(2 * i)) $display("FAIL t1_pixel[%0d]: got %h want %h", i, got, 16'h1000 + 16'(2 * i)); else pass_cnt++;
            total_cnt++;
            if ((i < last_log.size() && last_log[i]) !== (i % 4 == 3)) $display("FAIL t1_tlast[%0d]: got %b want %b", i, (i < last_log.size() && last_log[i]), (i % 4 == 3)); else pass_cnt++;
        end
    endtask

    task automatic test_rd_stall();
        logic [15:0] got;
        clear_logs();
        m_axis_tready = 1'b1;
        rd_ready_en   = 1'b0;
        pulse_fsync(32'h1000);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({o_Rd_Valid, o_Rd_Addr} !== {1'b1, 32'h1000}) $display("FAIL t2_hold[%0d]: got valid=%b addr=%h want valid=1 addr=00001000", i, o_Rd_Valid, o_Rd_Addr); else pass_cnt++;
            tick();
        end
        rd_ready_en = 1'b1;
        wait_idle();
        total_cnt++; if (o_Busy !== 1'b0) $display("FAIL t2_busy_fall: got %b want 0", o_Busy); else pass_cnt++;
        total_cnt++; if (acc_log.size() !== 4) $display("FAIL t2_read_count: got %0d want 4", acc_log.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            got = (i < pix_log.size()) ? pix_log[i] : 16'hFFFF;
            total_cnt++;
            if (got !== 16'h1000 + 16'(2 * i)) $display("FAIL t2_pixel[%0d]: got %h want %h", i, got, 16'h1000 + 16'(2 * i)); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ref_d, got;
        logic        ref_l;
        bit          seen, stable;
        clear_logs();
        m_axis_tready = 1'b0;
        seen   = 1'b0;
        stable = 1'b1;
        ref_d  = '0;
        ref_l  = 1'b0;
        pulse_fsync(32'h1000);
        repeat (20) begin
            if (m_axis_tvalid === 1'b1) begin
                if (!seen) begin
                    ref_d = m_axis_tdata;
                    ref_l = m_axis_tlast;
                    seen  = 1'b1;
                end else if (m_axis_tdata !== ref_d || m_axis_tlast !== ref_l) begin
                    stable = 1'b0;
                end
            end else if (seen) begin
                stable = 1'b0;
            end
            tick();
        end
        total_cnt++; if ({seen, ref_d} !== {1'b1, 16'h1000}) $display("FAIL t3_head: got seen=%b data=%h want seen=1 data=1000", seen, ref_d); else pass_cnt++;
        total_cnt++; if (stable !== 1'b1) $display("FAIL t3_stable: got %b want 1", stable); else pass_cnt++;
        total_cnt++; if (acc_log.size() > 4) $display("FAIL t3_credit: got %0d reads want <=4", acc_log.size()); else pass_cnt++;
        m_axis_tready = 1'b1;
        wait_idle();
        total_cnt++; if (pix_log.size() !== 8) $display("FAIL t3_pixel_count: got %0d want 8", pix_log.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            got = (i < pix_log.size()) ? pix_log[i] : 16'hFFFF;
            total_cnt++;
            if (got !== 16'h1000 + 16'(2 * i)) $display("FAIL t3_pixel[%0d]: got %h want %h", i, got, 16'h1000 + 16'(2 * i)); else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        logic [15:0] got;
        logic [31:0] ga;
        int          n;
        clear_logs();
        m_axis_tready = 1'b0;
        mem_allow     = 2;
        pulse_fsync(32'h1000);
        n = 0;
        while ((acc_log.size() < 4 || mem_allow > 0) && n < 50) begin
            tick();
            n++;
        end
        repeat (2) tick();
        total_cnt++; if (pend_addr.size() !== 2) $display("FAIL t4_outstanding: got %0d want 2", pend_addr.size()); else pass_cnt++;
        m_axis_tready = 1'b1;
        n = 0;
        while (pix_log.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        m_axis_tready = 1'b0;
        total_cnt++; if (pix_log.size() !== 3) $display("FAIL t4_pre_pixels: got %0d want 3", pix_log.size()); else pass_cnt++;
        pulse_fsync(32'h2000);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({m_axis_tvalid, o_Rd_Valid} !== 2'b00) $display("FAIL t4_drain[%0d]: got tvalid=%b rd_valid=%b want 0 0", i, m_axis_tvalid, o_Rd_Valid); else pass_cnt++;
            tick();
        end
        clear_logs();
        mem_allow = 1000000;
        wait_idle();
        total_cnt++; if (o_Busy !== 1'b0) $display("FAIL t4_busy_fall: got %b want 0", o_Busy); else pass_cnt++;
        ga = (acc_log.size() > 0) ? acc_log[0] : 32'hFFFF_FFFF;
        total_cnt++; if (ga !== 32'h2000) $display("FAIL t4_first_read: got %h want 00002000", ga); else pass_cnt++;
        total_cnt++; if (acc_log.size() !== 4) $display("FAIL t4_read_count: got %0d want 4", acc_log.size()); else pass_cnt++;
        total_cnt++; if (pix_log.size() !== 8) $display("FAIL t4_pixel_count: got %0d want 8", pix_log.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            got = (i < pix_log.size()) ? pix_log[i] : 16'hFFFF;
            total_cnt++;
            if (got !== 16'h2000 + 16'(2 * i)) $display("FAIL t4_pixel[%0d]: got %h want %h", i, got, 16'h2000 + 16'(2 * i)); else pass_cnt++;
        end
    endtask

    task automatic test_fsync_hold();
        logic [15:0] got;
        clear_logs();
        m_axis_tready = 1'b1;
        i_Frame_Base  = 32'h1000;
        i_fsync       = 1'b1;
        repeat (4) tick();
        i_fsync = 1'b0;
        wait_idle();
        total_cnt++; if (o_Busy !== 1'b0) $display("FAIL t5_busy_fall: got %b want 0", o_Busy); else pass_cnt++;
        total_cnt++; if (acc_log.size() !== 4) $display("FAIL t5_read_count: got %0d want 4", acc_log.size()); else pass_cnt++;
        total_cnt++; if (pix_log.size() !== 8) $display("FAIL t5_pixel_count: got %0d want 8", pix_log.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            got = (i < pix_log.size()) ? pix_log[i] : 16'hFFFF;
            total_cnt++;
            if (got !== 16'h1000 + 16'(2 * i)) $display("FAIL t5_pixel[%0d]: got %h want %h", i, got, 16'h1000 + 16'(2 * i)); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        clear_logs();
        m_axis_tready = 1'b0;
        pulse_fsync(32'h1000);
        repeat (3) tick();
        i_Reset = 1'b1;
        #1;
        total_cnt++; if ({o_Busy, o_Rd_Valid, m_axis_tvalid} !== 3'b000) $display("FAIL t7_reset_mid: got %b want 000", {o_Busy, o_Rd_Valid, m_axis_tvalid}); else pass_cnt++;
        repeat (2) tick();
        i_Reset = 1'b0;
        repeat (4) tick();
        clear_logs();
        m_axis_tready = 1'b1;
        pulse_fsync(32'h3000);
        wait_idle();
        total_cnt++; if (pix_log.size() !== 8) $display("FAIL t7_pixel_count: got %0d want 8", pix_log.size()); else pass_cnt++;
        got = (pix_log.size() > 0) ? pix_log[0] : 16'hFFFF;
        total_cnt++; if (got !== 16'h3000) $display("FAIL t7_first_pixel: got %h want 3000", got); else pass_cnt++;
    endtask

`ifdef STARVE_STATS_EN
    task automatic test_starve();
        do_reset();
        total_cnt++; if (o_Starve_Count !== 16'd0) $display("FAIL t6_starve_reset: got %0d want 0", o_Starve_Count); else pass_cnt++;
        m_axis_tready = 1'b1;
        lat = 10;
        repeat (5) tick();
        total_cnt++; if (o_Starve_Count !== 16'd0) $display("FAIL t6_starve_idle: got %0d want 0", o_Starve_Count); else pass_cnt++;
        clear_logs();
        pulse_fsync(32'h1000);
        wait_idle();
        total_cnt++; if (o_Starve_Count !== 16'd11) $display("FAIL t6_starve_frame: got %0d want 11", o_Starve_Count); else pass_cnt++;
        repeat (10) tick();
        total_cnt++; if (o_Starve_Count !== 16'd11) $display("FAIL t6_starve_hold: got %0d want 11", o_Starve_Count); else pass_cnt++;
        lat = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_rd_stall();
        test_backpressure();
        test_abort();
        test_fsync_hold();
        test_reset_mid();
`ifdef STARVE_STATS_EN
        test_starve();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
